// File: rtl/spi_master_burst.sv
// spi_master_burst: parametrised SPI master with multi-word bursts under one
// chip select and run-time CPOL/CPHA. MSB-first words with a valid/ready
// transmit handshake and a one-cycle receive strobe.
// Optional build macro SPI_LOOPBACK_EN adds a 'loopback' input that routes the
// internal mosi back to the receive sampler instead of the miso pin.
module spi_master_burst #(
  parameter int DATA_W   = 8,
  parameter int CLK_DIV  = 50,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              miso
);

  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int BIT_W   = $clog2(2 * DATA_W);
  localparam int TMR_MAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                                : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_WAIT, S_HOLD, S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [DATA_W-1:0]  tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]  rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]  rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               last_q, last_d;
  logic               cpol_q, cpol_d;
  logic               cpha_q, cpha_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;

  logic edge_now, word_done, sample_now, drive_now, accept, cpha_load, sample_bit;

`ifdef SPI_LOOPBACK_EN
  logic lpbk_q, lpbk_d;
  assign sample_bit = lpbk_q ? mosi_q : miso;
`else
  assign sample_bit = miso;
`endif

  // Edge decode: an SCLK edge happens on the divider wrap; even edges lead,
  // odd edges trail. cpha picks which parity samples and which drives.
  assign edge_now   = (state_q == S_SHIFT) && (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign word_done  = edge_now && (bit_cnt_q == BIT_W'(2 * DATA_W - 1));
  assign sample_now = edge_now && (bit_cnt_q[0] == cpha_q);
  assign drive_now  = edge_now && (bit_cnt_q[0] != cpha_q) && !word_done;
  assign cpha_load  = (state_q == S_IDLE) ? cpha : cpha_q;

  // Ready only where a word can be taken; held low while reset is asserted.
  assign tx_ready = rst_n && ((state_q == S_IDLE) || (state_q == S_WAIT) ||
                              (word_done && !last_q));
  assign accept   = tx_valid && tx_ready;

  assign busy     = (state_q != S_IDLE);
  assign cs_n     = cs_n_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  // Next-state, counters, shift registers and pin levels.
  always_comb begin
    // NOTE: every *_d gets its hold value first so no path leaves a latch.
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tmr_d      = tmr_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    last_d     = last_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
`ifdef SPI_LOOPBACK_EN
    lpbk_d     = lpbk_q;
`endif

    if (sample_now) rx_sr_d = {rx_sr_q[DATA_W-2:0], sample_bit};
    if (drive_now) begin
      mosi_d  = tx_sr_q[DATA_W-1];
      tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
    end

    unique case (state_q)
      S_IDLE: begin
        sclk_d = cpol;
        if (accept) begin
          cpol_d  = cpol;
          cpha_d  = cpha;
`ifdef SPI_LOOPBACK_EN
          lpbk_d  = loopback;
`endif
          cs_n_d  = 1'b0;
          tmr_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tmr_q == TMR_W'(CS_SETUP - 1)) begin
          tmr_d     = '0;
          div_cnt_d = '0;
          state_d   = S_SHIFT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (edge_now) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (word_done) begin
            bit_cnt_d  = '0;
            rx_data_d  = rx_sr_d;
            rx_valid_d = 1'b1;
            if (last_q) begin
              tmr_d   = '0;
              state_d = S_HOLD;
            end else if (!tx_valid) begin
              state_d = S_WAIT;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (accept) state_d = S_SHIFT;
      end
      S_HOLD: begin
        if (tmr_q == TMR_W'(CS_HOLD - 1)) begin
          tmr_d   = '0;
          cs_n_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_GAP: begin
        if (tmr_q == TMR_W'(CS_GAP - 1)) begin
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Word load is common to IDLE, WAIT and the back-to-back slot.
    if (accept) begin
      last_d    = tx_last;
      bit_cnt_d = '0;
      div_cnt_d = '0;
      if (!cpha_load) begin
        mosi_d  = tx_data[DATA_W-1];
        tx_sr_d = {tx_data[DATA_W-2:0], 1'b0};
      end else begin
        tx_sr_d = tx_data;
      end
    end
  end

  // State register; every flop returns to its idle value on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      tmr_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      last_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
`ifdef SPI_LOOPBACK_EN
      lpbk_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates so every flop sees the pre-edge values.
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tmr_q      <= tmr_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      last_q     <= last_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
`ifdef SPI_LOOPBACK_EN
      lpbk_q     <= lpbk_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_master_burst.sv
// Self-checking bench for spi_master_burst (DATA_W=8, CLK_DIV=4). A behavioural
// SPI slave drives miso from a bit list and records mosi on its sample edges;
// expected words come from that slave and the stimulus arrays.
module tb_spi_master_burst;

  localparam int DATA_W   = 8;
  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_GAP   = 4;
  localparam int WORD_CYC = 2 * DATA_W * CLK_DIV;
  localparam int LIMIT    = 2000;

  logic clk = 1'b0;
  logic rst_n, cpol, cpha, tx_valid, tx_last, miso;
  logic [7:0] tx_data;
  logic tx_ready, rx_valid, busy, cs_n, sclk, mosi;
  logic [7:0] rx_data;
`ifdef SPI_LOOPBACK_EN
  logic loopback = 1'b0;
`endif

  spi_master_burst #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP),
                     .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .cs_n(cs_n),
    .sclk(sclk), .mosi(mosi),
`ifdef SPI_LOOPBACK_EN
    .loopback(loopback),
`endif
    .miso(miso)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Stimulus words, slave reply words and expected receive words.
  logic [7:0] tx_w [0:7];
  logic [7:0] sl_w [0:7];
  logic [7:0] exp_rx [0:7];
  bit         lb_expect = 1'b0;
  logic       sl_bits [0:63];
  int         sl_len = 0;

  // Behavioural slave: latches mode at cs_n fall, shifts miso on the
  // non-sampling edge (plus a preload for cpha=0), records mosi on sampling edges.
  logic s_cp = 1'b0, s_ph = 1'b0, s_cs_prev, s_sclk_prev;
  int   sl_idx = 0;
  logic mo_log [$];

  task automatic slave_drive();
    if (sl_idx < sl_len) miso = sl_bits[sl_idx];
    sl_idx++;
  endtask

  always @(sclk or cs_n) begin
    if (cs_n !== s_cs_prev) begin
      s_cs_prev = cs_n;
      if (cs_n === 1'b0) begin
        s_cp = cpol; s_ph = cpha; sl_idx = 0;
        if (!s_ph) slave_drive();
      end
    end else if (cs_n === 1'b0 && sclk !== s_sclk_prev) begin
      if (sclk === ~(s_cp ^ s_ph)) mo_log.push_back(mosi);
      else slave_drive();
    end
    s_sclk_prev = sclk;
  end

  // Pin monitor sampled mid-cycle: cumulative totals the test steps diff.
  int cyc = 0, cs_low_tot = 0, cs_fall_tot = 0, rise_tot = 0, mosi_bad_tot = 0;
  logic m_cs_prev = 1'b1, m_sclk_prev = 1'b0, m_mosi_prev = 1'b0;
  logic [7:0] rx_log [$];
  int rx_cyc [$];

  always @(negedge clk) begin
    cyc++;
    if (cs_n === 1'b0) cs_low_tot++;
    if (m_cs_prev === 1'b1 && cs_n === 1'b0) cs_fall_tot++;
    if (cs_n === 1'b0 && m_sclk_prev === 1'b0 && sclk === 1'b1) rise_tot++;
    if (cs_n === 1'b0 && sclk !== m_sclk_prev && sclk === ~(s_cp ^ s_ph) &&
        mosi !== m_mosi_prev) mosi_bad_tot++;
    if (rx_valid === 1'b1) begin
      rx_log.push_back(rx_data);
      rx_cyc.push_back(cyc);
    end
    m_cs_prev = cs_n; m_sclk_prev = sclk; m_mosi_prev = mosi;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s: observed no event expected one within %0d cycles", tag, LIMIT);
  endtask

  task automatic load_slave(input int n);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) sl_bits[8*i+b] = sl_w[i][7-b];
      exp_rx[i] = lb_expect ? tx_w[i] : sl_w[i];
    end
    sl_len = 8 * n;
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (tx_ready !== 1'b1) timeout(tag);
  endtask

  // Waits for the end of a burst and checks SCLK sits at the latched idle level.
  task automatic wait_idle(input string tag, input logic cp);
    int t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (busy !== 1'b0) timeout(tag);
    else check({tag, "_sclk_idle"}, sclk, cp);
  endtask

  task automatic check_words(input string tag, input int rx0, input int mo0, input int n);
    logic [7:0] w;
    check({tag, "_rx_count"}, rx_log.size() - rx0, n);
    for (int i = 0; i < n; i++) begin
      if (rx0 + i < rx_log.size())
        check($sformatf("%s_rx%0d", tag, i), rx_log[rx0+i], exp_rx[i]);
      if (mo0 + 8*(i+1) <= mo_log.size()) begin
        w = '0;
        for (int b = 0; b < 8; b++) w = {w[6:0], mo_log[mo0+8*i+b]};
        check($sformatf("%s_mosi%0d", tag, i), w, tx_w[i]);
      end else begin
        timeout($sformatf("%s_mosi%0d", tag, i));
      end
    end
  endtask

  // One complete burst of n words; gap_max>0 drops tx_valid for random
  // stretches between words, flip toggles cpol/cpha after the first accept.
  task automatic run_burst(input logic cp, input logic ph, input int n,
                           input int gap_max, input bit flip, input string tag);
    int rx0, mo0, bad0;
    cpol = cp; cpha = ph;
    load_slave(n);
    repeat (2) @(posedge clk);
    #1;
    rx0 = rx_log.size(); mo0 = mo_log.size(); bad0 = mosi_bad_tot;
    for (int i = 0; i < n; i++) begin
      tx_data = tx_w[i]; tx_last = (i == n - 1); tx_valid = 1'b1;
      wait_ready(tag);
      @(posedge clk);
      #1;
      if (flip && i == 0) begin cpol = ~cp; cpha = ~ph; end
      if (gap_max > 0 && i != n - 1) begin
        tx_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) @(posedge clk);
        #1;
      end
    end
    tx_valid = 1'b0; tx_last = 1'b0;
    wait_idle(tag, cp);
    check_words(tag, rx0, mo0, n);
    check({tag, "_mosi_stable"}, mosi_bad_tot - bad0, 0);
    cpol = cp; cpha = ph;
  endtask

  initial begin
    int c0, f0, r0, rx0, mo0, t;
    rst_n = 1'b0; cpol = 1'b0; cpha = 1'b0; miso = 1'b0;
    tx_valid = 1'b0; tx_last = 1'b0; tx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_tx_ready", tx_ready, 1'b1);

    // Mode 0 single word.
    tx_w[0] = 8'hA5; sl_w[0] = 8'h3C;
    c0 = cs_low_tot; r0 = rise_tot;
    run_burst(1'b0, 1'b0, 1, 0, 1'b0, "m0");
    check("m0_cs_low_cycles", cs_low_tot - c0, CS_SETUP + WORD_CYC + CS_HOLD);
    check("m0_sclk_rises", rise_tot - r0, 8);

    // Mode 3 single word; SCLK idles high.
    tx_w[0] = 8'h81; sl_w[0] = 8'h7E;
    run_burst(1'b1, 1'b1, 1, 0, 1'b0, "m3");
    check("m3_idle_high", sclk, 1'b1);

    // Three-word burst with tx_valid held: one cs_n window, no SCLK gaps.
    tx_w[0] = 8'h11; tx_w[1] = 8'h22; tx_w[2] = 8'h33;
    for (int i = 0; i < 3; i++) sl_w[i] = 8'($urandom);
    c0 = cs_low_tot; f0 = cs_fall_tot; r0 = rise_tot; rx0 = rx_log.size();
    run_burst(1'b0, 1'b0, 3, 0, 1'b0, "b3");
    check("b3_cs_low_cycles", cs_low_tot - c0, CS_SETUP + 3 * WORD_CYC + CS_HOLD);
    check("b3_cs_falls", cs_fall_tot - f0, 1);
    check("b3_sclk_rises", rise_tot - r0, 24);
    if (rx_cyc.size() >= rx0 + 3) begin
      check("b3_rx_gap1", rx_cyc[rx0+1] - rx_cyc[rx0], WORD_CYC);
      check("b3_rx_gap2", rx_cyc[rx0+2] - rx_cyc[rx0+1], WORD_CYC);
    end else begin
      timeout("b3_rx_gaps");
    end

    // Same burst with a 20-cycle stall after word 0: WAIT, then resume.
    for (int i = 0; i < 3; i++) sl_w[i] = 8'($urandom);
    cpol = 1'b0; cpha = 1'b0; load_slave(3);
    repeat (2) @(posedge clk);
    #1;
    rx0 = rx_log.size(); mo0 = mo_log.size();
    tx_data = tx_w[0]; tx_last = 1'b0; tx_valid = 1'b1;
    wait_ready("wt_first");
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    t = 0;
    while (rx_log.size() == rx0 && t < LIMIT) begin @(negedge clk); t++; end
    if (rx_log.size() == rx0) timeout("wt_first_rx");
    repeat (20) @(negedge clk);
    check("wt_sclk_idle", sclk, 1'b0);
    check("wt_cs_n", cs_n, 1'b0);
    check("wt_tx_ready", tx_ready, 1'b1);
    check("wt_busy", busy, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 1; i < 3; i++) begin
      tx_data = tx_w[i]; tx_last = (i == 2); tx_valid = 1'b1;
      wait_ready("wt_resume");
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0; tx_last = 1'b0;
    wait_idle("wt", 1'b0);
    check_words("wt", rx0, mo0, 3);

    // Reset in the middle of a word (bit 4), then a clean 0xC3 burst.
    tx_w[0] = 8'hF0; tx_w[1] = 8'h0F; sl_w[0] = 8'h55; sl_w[1] = 8'hAA;
    cpol = 1'b0; cpha = 1'b0; load_slave(2);
    repeat (2) @(posedge clk);
    #1;
    r0 = rise_tot;
    tx_data = tx_w[0]; tx_last = 1'b0; tx_valid = 1'b1;
    wait_ready("rs_accept");
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    t = 0;
    while (rise_tot - r0 < 4 && t < LIMIT) begin @(negedge clk); t++; end
    if (rise_tot - r0 < 4) timeout("rs_bit4");
    #2 rst_n = 1'b0;
    #1;
    check("rs_cs_n", cs_n, 1'b1);
    check("rs_sclk", sclk, 1'b0);
    check("rs_busy", busy, 1'b0);
    check("rs_rx_valid", rx_valid, 1'b0);
    check("rs_tx_ready", tx_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tx_w[0] = 8'hC3; sl_w[0] = 8'($urandom);
    run_burst(1'b0, 1'b0, 1, 0, 1'b0, "rs_after");

`ifdef SPI_LOOPBACK_EN
    // Loopback in mode 1 with miso held low.
    tx_w[0] = 8'h5A; sl_w[0] = 8'h00;
    loopback = 1'b1; lb_expect = 1'b1;
    run_burst(1'b0, 1'b1, 1, 0, 1'b0, "lb_on");
    loopback = 1'b0; lb_expect = 1'b0;
    run_burst(1'b0, 1'b1, 1, 0, 1'b0, "lb_off");
`endif

    // Randomised bursts: random mode, length, data and inter-word stalls;
    // one burst toggles cpol/cpha mid-burst, which must have no effect.
    for (int k = 0; k < 6; k++) begin
      int n;
      logic cp, ph;
      n = int'($urandom_range(4, 1));
      cp = 1'($urandom); ph = 1'($urandom);
      for (int i = 0; i < n; i++) begin
        tx_w[i] = 8'($urandom);
        sl_w[i] = 8'($urandom);
      end
      run_burst(cp, ph, n, (k % 2) ? 30 : 0, (k == 2), $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Last-resort bound on total run time.
  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: observed no end of test expected within 60000 cycles");
    $fatal(1);
  end

endmodule

// File: doc/spi_master_burst.md
Name: spi_master_burst

Overview:
- Parametrised successor SPI master for the accelerometer path.
- Adds the following over the fixed-byte master:
  - configurable word width and SCLK divider;
  - all four CPOL/CPHA modes, selected at run time;
  - multi-word bursts under a single chip select, with a valid/ready transmit handshake;
  - a per-word receive strobe feeding the downstream FIFO.
- Sits between the command sequencer / FIFO and the sensor pins.

Parameters:
DATA_W, 8, bits per SPI word (>=2), MSB first
CLK_DIV, 50, clk cycles per SCLK half-period (>=2); SCLK = clk/(2*CLK_DIV)
CS_SETUP, 2, clk cycles from cs_n falling to first SCLK edge
CS_HOLD, 2, clk cycles from last SCLK edge to cs_n rising
CS_GAP, 4, minimum clk cycles cs_n stays high between bursts

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
cpol  in  1  SCLK idle level; latched at burst start
cpha  in  1  0: sample on leading edge; 1: shift on leading edge; latched at burst start
tx_data  in  DATA_W  word to transmit
tx_valid  in  1  tx_data valid
tx_last  in  1  qualifies tx_data: final word of burst
tx_ready  out  1  word accepted when tx_valid && tx_ready
rx_data  out  DATA_W  last received word
rx_valid  out  1  one-cycle pulse, rx_data updated
busy  out  1  high in any state except IDLE
cs_n  out  1  chip select, active-low
sclk  out  1  SPI clock
mosi  out  1  master out
miso  in  1  master in; sampled directly, no synchroniser

Behaviour:
- Reset (async, any state):
  - state=IDLE; cs_n=1, sclk=0, mosi=0;
  - rx_data=0, rx_valid=0, tx_ready=0, busy=0;
  - all counters=0.
- States: IDLE, SETUP, SHIFT, WAIT, HOLD, GAP.
- IDLE:
  - tx_ready=1; sclk follows cpol registered.
  - On accept: latch word, tx_last, cpol, cpha; cs_n<=0; go to SETUP.
  - For cpha=0, mosi<=word MSB on the same edge.
- SETUP: count CS_SETUP cycles, then go to SHIFT.
- SHIFT:
  - div_cnt counts 0..CLK_DIV-1; sclk toggles on wrap.
  - Each word is 2*DATA_W edges.
  - cpha=0: sample miso on leading edges; drive next bit on trailing edges (except the final trailing edge).
  - cpha=1: drive bit on leading edges; sample on trailing edges.
  - Receive shift register is MSB first.
- Word complete (final edge of the word):
  - rx_data<=shift register; rx_valid pulses 1 cycle.
  - If the current word is last: go to HOLD.
  - Else: tx_ready=1 that cycle.
    - If tx_valid, load the next word back-to-back (no extra SCLK gap; cpha=0 drives its MSB immediately).
    - Otherwise go to WAIT.
- WAIT:
  - cs_n=0, sclk=idle level, tx_ready=1.
  - On accept, load the word and re-enter SHIFT with div_cnt=0.
- HOLD: CS_HOLD cycles; then cs_n<=1, go to GAP.
- GAP:
  - CS_GAP cycles, tx_ready=0, then IDLE.
  - A tx_valid held high during GAP is accepted in IDLE.
- tx_ready is 0 in SETUP, HOLD and GAP, and during SHIFT except on the word-complete cycle.
- cpol/cpha changes mid-burst are ignored until the next IDLE accept.
- rx_valid has no backpressure; the consumer must take data in the pulse cycle.
- Counter widths: div_cnt $clog2(CLK_DIV); bit_cnt $clog2(2*DATA_W).
- Neither counter may wrap except as defined above.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined:
  - adds input port loopback (1 bit); when high, the sampled bit is the internal mosi, not miso;
  - loopback is latched at burst start with cpol/cpha.
- Undefined: the port is absent; miso is always sampled.

Test Plan:
- Mode 0, DATA_W=8, CLK_DIV=4, single word 0xA5 with tx_last=1; slave model drives 0x3C.
  - mosi=1,0,1,0,0,1,0,1 on rising edges; rx_data=0x3C with one rx_valid pulse.
  - cs_n low for 2+64+2 cycles; 8 sclk rising edges; sclk idles at 0.
- Mode 3, word 0x81; slave returns 0x7E.
  - sclk idles at 1; mosi changes on falling edges, sampled on rising edges; rx_data=0x7E.
- Burst of 0x11, 0x22, 0x33 with tx_valid held high and tx_last on the third word.
  - cs_n stays low continuously; 24 sclk pulses with no gap.
  - Three rx_valid pulses, exactly 16*CLK_DIV cycles apart.
- Same burst with tx_valid dropped 20 cycles after the first word completes.
  - WAIT entered: sclk idle, cs_n=0, tx_ready=1.
  - Resumes cleanly on the second word; rx data correct.
- rst_n asserted mid-word (bit 4) of a burst.
  - Immediately cs_n=1, sclk=0, busy=0, rx_valid=0.
  - After release, the next burst 0xC3 completes correctly.
- SPI_LOOPBACK_EN defined, loopback=1, mode 1, word 0x5A with miso tied 0: rx_data=0x5A.
- SPI_LOOPBACK_EN defined, loopback=0, same stimulus: rx_data=0x00.
